// File: rtl/sram_access_arbiter.sv
// rtl/sram_access_arbiter.sv - single-port SRAM arbiter between pixel-fetch reads and output-buffer writes
// Optional build macro: ARB_WRITE_PRIORITY_EN (pending writes always win in IDLE).
module sram_access_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic              busy
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;   // 0 = read, 1 = write
    logic             cur_write;
    logic             grant;
    logic             grant_write;

    always_comb begin
        state_next   = state;
        grant        = 1'b0;
        grant_write  = 1'b0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        rd_valid     = 1'b0;
        wr_done      = 1'b0;
        case (state)
            IDLE: begin
                if (rd_req || wr_req) begin
                    grant = 1'b1;
`ifdef ARB_WRITE_PRIORITY_EN
                    grant_write = wr_req;
`else
                    // On a tie, the requester that did not win last time goes now.
                    grant_write = wr_req && (!rd_req || !last_grant);
`endif
                    state_next = grant_write ? WRITE : READ;
                end
            end
            READ: begin
                mem_read_en = 1'b1;
                if (cnt == '0) state_next = RESP;
            end
            WRITE: begin
                mem_write_en = 1'b1;
                if (cnt == '0) state_next = RESP;
            end
            RESP: begin
                rd_valid   = !cur_write;
                wr_done    = cur_write;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b0;
            cur_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rd_data    <= '0;
        end else begin
            state <= state_next;
            if (grant) begin
                cnt       <= CNT_LOAD;
                cur_write <= grant_write;
                mem_addr  <= grant_write ? wr_addr : rd_addr;
                if (grant_write) mem_wdata <= wr_data;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            // SRAM read data is only guaranteed in the final access cycle.
            if (state == READ && cnt == '0) rd_data <= mem_rdata;
            if (state == RESP) last_grant <= cur_write;
        end
    end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb/tb_sram_access_arbiter.sv - randomized self-checking bench against a transaction-timing model
module tb_sram_access_arbiter;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_req = 1'b0;
    logic [31:0] rd_addr = '0;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        wr_req = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        wr_done;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_read_en;
    logic        mem_write_en;
    logic        busy;

    sram_access_arbiter #(.WAIT_CYCLES(W), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Model: one outstanding access described by its grant cycle and kind.
    bit          m_active = 0;
    int          m_g = -100;
    bit          m_wr = 0;
    bit          m_last_wr = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rd = '0;
    bit          done_rd = 0;
    bit          done_wr = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic sample();
        bit strobe;
        bit done;
        @(posedge clk);
        #1;
        cyc++;
        strobe = m_active && (cyc >= m_g + 1) && (cyc <= m_g + W);
        done   = m_active && (cyc == m_g + W + 1);
        check_eq("mem_read_en",  32'(mem_read_en),  32'(strobe && !m_wr));
        check_eq("mem_write_en", 32'(mem_write_en), 32'(strobe && m_wr));
        check_eq("strobe_overlap", 32'(mem_read_en && mem_write_en), 32'd0);
        check_eq("rd_valid", 32'(rd_valid), 32'(done && !m_wr));
        check_eq("wr_done",  32'(wr_done),  32'(done && m_wr));
        check_eq("busy", 32'(busy), 32'(m_active && cyc >= m_g + 1));
        check_eq("mem_addr",  mem_addr,  m_addr);
        check_eq("mem_wdata", mem_wdata, m_wdata);
        check_eq("rd_data",   rd_data,   m_rd);
        done_rd = done && !m_wr;
        done_wr = done && m_wr;
        if (done_rd) rd_req = 1'b0;
        if (done_wr) wr_req = 1'b0;
    endtask

    task automatic commit();
        if (rst) begin
            m_active  = 0;
            m_last_wr = 0;
            m_addr    = '0;
            m_wdata   = '0;
            m_rd      = '0;
        end else if (m_active && cyc == m_g + W + 1) begin
            m_last_wr = m_wr;
            m_active  = 0;
        end else if (m_active) begin
            if (cyc == m_g + W && !m_wr) m_rd = mem_rdata;
        end else if (rd_req || wr_req) begin
`ifdef ARB_WRITE_PRIORITY_EN
            m_wr = wr_req;
`else
            if (rd_req && wr_req) m_wr = !m_last_wr;
            else                  m_wr = wr_req;
`endif
            m_g      = cyc;
            m_active = 1;
            m_addr   = m_wr ? wr_addr : rd_addr;
            if (m_wr) m_wdata = wr_data;
        end
    endtask

    initial begin
        repeat (3) begin
            sample();
            commit();
        end

        // Single read of 0x100 returning 0xDEADBEEF.
        sample();
        rst = 1'b0;
        rd_req = 1'b1;
        rd_addr = 32'h100;
        mem_rdata = 32'hDEADBEEF;
        commit();
        repeat (8) begin
            sample();
            commit();
        end
        check_eq("rd_data_hold", rd_data, 32'hDEADBEEF);

        // Single write of 0xA5A5A5A5 to 0x2000.
        sample();
        wr_req = 1'b1;
        wr_addr = 32'h2000;
        wr_data = 32'hA5A5A5A5;
        commit();
        repeat (6) begin
            sample();
            commit();
        end

        // Both requesters held, re-raising the cycle after each pulse.
        for (int i = 0; i < 40; i++) begin
            sample();
            mem_rdata = $urandom;
            if (!rd_req && !done_rd) begin rd_req = 1'b1; rd_addr = $urandom; end
            if (!wr_req && !done_wr) begin wr_req = 1'b1; wr_addr = $urandom; wr_data = $urandom; end
            commit();
        end

        // Drain, then reset during the second strobe cycle of a write.
        for (int i = 0; i < 8; i++) begin
            sample();
            commit();
        end
        sample();
        wr_req = 1'b1;
        wr_addr = 32'h3000;
        wr_data = 32'h1234_5678;
        commit();
        sample();
        commit();
        sample();
        rst = 1'b1;
        commit();
        sample();
        rst = 1'b0;
        rd_req = 1'b1;
        rd_addr = 32'h4000;
        commit();
        repeat (10) begin
            sample();
            commit();
        end

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            sample();
            mem_rdata = $urandom;
            rst = ($urandom_range(0, 79) == 0);
            if (!rd_req && !done_rd && $urandom_range(0, 2) == 0) begin
                rd_req = 1'b1;
                rd_addr = $urandom;
            end
            if (!wr_req && !done_wr && $urandom_range(0, 2) == 0) begin
                wr_req = 1'b1;
                wr_addr = $urandom;
                wr_data = $urandom;
            end
            commit();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_access_arbiter.md
# sram_access_arbiter

Arbitrates the single SRAM port between the input pixel fetch path (read requester) and the output buffer's 32-pixel word writes (write requester). Each access occupies the SRAM for a fixed number of wait cycles, then a one-cycle completion pulse goes back to the requester. The block sits between the read controller / output buffer and the SRAM model, and sequences all memory traffic of the Sobel engine.

## Interface
- WAIT_CYCLES, 2, cycles the SRAM enables are held per access (>=1)
- ADDR_W, 32, address width
- DATA_W, 32, data word width

- clk  in  1  system clock; one clock domain
- rst  in  1  reset, synchronous and active-high
- rd_req  in  1  level read request; held until rd_valid
- rd_addr  in  ADDR_W  read address; sampled at grant
- rd_valid  out  1  one-cycle pulse: rd_data valid, read complete
- rd_data  out  DATA_W  registered read data; holds until the next read completes
- wr_req  in  1  level write request; held until wr_done
- wr_addr  in  ADDR_W  write address; sampled at grant
- wr_data  in  DATA_W  write word; sampled at grant
- wr_done  out  1  one-cycle pulse: write committed
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data; valid in the last access cycle
- mem_read_en  out  1  SRAM read strobe
- mem_write_en  out  1  SRAM write strobe
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: if no request is pending, stay. Otherwise choose a winner, latch its address (and data for writes), load the wait counter with WAIT_CYCLES-1, and go to READ or WRITE.
- Winner selection with exactly one request pending: that request wins. With both pending: the requester not granted last time wins (round-robin via the last_grant flop). Reset value of last_grant = READ, so the write wins the first tie.
- READ/WRITE: drive mem_addr from the latch. mem_read_en or mem_write_en stays high for the whole state. The counter decrements each cycle. When the counter reaches 0, go to RESP; for READ, rd_data captures mem_rdata on that cycle.
- RESP: pulse rd_valid or wr_done and update last_grant. Requests are ignored in RESP, so a requester that drops req on the pulse cycle is never double-served. Always return to IDLE.
- Wait counter width is $clog2(WAIT_CYCLES+1) bits. Address and data pass through unmodified (no arithmetic).
- Outside an access, mem_addr and mem_wdata hold their last latched values. The strobes are 0.

## Timing
- Request high in IDLE at cycle t:
  - strobe high during cycles t+1 .. t+WAIT_CYCLES
  - done pulse at cycle t+WAIT_CYCLES+1
  - earliest next grant at cycle t+WAIT_CYCLES+2
- Throughput: one access per WAIT_CYCLES+2 cycles.
- mem_read_en and mem_write_en are never high in the same cycle.
- Reset values: state=IDLE; mem_read_en, mem_write_en, rd_valid, wr_done, busy = 0; mem_addr, mem_wdata, rd_data = 0; last_grant=READ.
- Reset mid-access: strobes drop in the cycle after rst is sampled. No done pulse is issued, the access is abandoned, and the requester must re-request.
- Request withdrawn mid-access (protocol violation): the access still completes and the pulse is still issued.
- Both requests arriving in the same cycle as a RESP pulse: arbitrated in the following IDLE cycle using the updated last_grant.

## Configuration
- ARB_WRITE_PRIORITY_EN:
  - Defined: a pending wr_req always beats rd_req in IDLE. last_grant is still updated but not used for selection. This guarantees the output buffer never stalls the edge pipeline, and reads may starve.
  - Undefined: round-robin as described in Operation.

## Test plan
- Reset, then a single read of 0x100 with mem_rdata=0xDEADBEEF, WAIT_CYCLES=2 -> mem_read_en high for 2 cycles, rd_valid pulses 3 cycles after the request with rd_data=0xDEADBEEF, and rd_data holds afterwards.
- Single write of addr 0x2000, data 0xA5A5A5A5 -> mem_write_en high 2 cycles with mem_addr=0x2000 and mem_wdata=0xA5A5A5A5, wr_done pulses exactly once.
- rd_req and wr_req both held continuously, round-robin build -> grants alternate W,R,W,R, each done pulse spaced 4 cycles apart, and the strobes never overlap.
- Same stimulus with ARB_WRITE_PRIORITY_EN defined -> only writes are granted while wr_req is held, and the read is granted on the first IDLE after wr_req drops.
- Assert rst during the second strobe cycle of a write -> no wr_done, strobes low on the next cycle, busy=0, and a subsequent tie grants the write first.
- Requester drops req on its done pulse and re-raises it next cycle -> exactly one pulse per request and no duplicate access.
